// File: rtl/apb_pkg.sv
// Shared APB definitions: bus widths, slave-select address bit and the completer FSM states.
package apb_pkg;

  localparam int unsigned APB_ADDR_W      = 8;
  localparam int unsigned APB_DATA_W      = 8;
  localparam int unsigned APB_SLV_SEL_BIT = 8;
  localparam int unsigned APB_CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

endpackage

// File: rtl/apb_slv_mem.sv
// Register array for the APB wait-state completer: synchronous write, asynchronous read.
module apb_slv_mem #(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IDX_W  = 6
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [IDX_W-1:0]  i_raddr,
  output logic [DATA_W-1:0] o_rdata_c
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_c = r_mem[i_raddr];

endmodule

// File: rtl/apb_wait_slave.sv
// APB completer with a register file, programmable wait states and PSLVERR responses.
// Optional APB_SLV_RO_REGION_EN makes the top 8 registers read-only (writes error out).
module apb_wait_slave
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W      = APB_ADDR_W,
  parameter int unsigned DATA_W      = APB_DATA_W,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR
);

  localparam int unsigned      IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]  DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  state_t              r_state;
  logic [APB_CNT_W-1:0] r_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_write;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_viol;

  state_t              w_state_nxt;
  logic [APB_CNT_W-1:0] w_cnt_nxt;
  logic [ADDR_W-1:0]   w_addr_nxt;
  logic                w_write_nxt;
  logic [DATA_W-1:0]   w_wdata_nxt;
  logic                w_viol_nxt;
  logic                w_setup;
  logic                w_accept;
  logic                w_r_ok;
  logic                w_n_ok;
  logic                w_r_ro;
  logic                w_n_ro;
  logic                w_err;
  logic                w_we;
  logic [DATA_W-1:0]   w_mem_rdata;
  logic [DATA_W-1:0]   w_rd_data;

  assign w_setup  = PSEL && !PENABLE;
  assign w_accept = w_setup && (r_state != WAIT);

  assign w_r_ok = ({1'b0, r_addr} < DEPTH_LIM);
  assign w_n_ok = ({1'b0, w_addr_nxt} < DEPTH_LIM);

`ifdef APB_SLV_RO_REGION_EN
  localparam logic [ADDR_W:0] RO_BASE = (ADDR_W + 1)'(DEPTH - 8);
  assign w_r_ro = ({1'b0, r_addr} >= RO_BASE);
  assign w_n_ro = ({1'b0, w_addr_nxt} >= RO_BASE);
`else
  assign w_r_ro = 1'b0;
  assign w_n_ro = 1'b0;
`endif

  // Next-state, wait counter and setup-phase capture
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_addr_nxt  = r_addr;
    w_write_nxt = r_write;
    w_wdata_nxt = r_wdata;
    w_viol_nxt  = r_viol;
    unique case (r_state)
      IDLE: begin
        if (PSEL && PENABLE) begin
          w_viol_nxt  = 1'b1;
          w_state_nxt = DONE;
        end
      end
      WAIT: begin
        if (!PSEL) begin
          w_state_nxt = IDLE;
        end else if (r_cnt == '0) begin
          w_state_nxt = DONE;
        end else begin
          w_cnt_nxt = r_cnt - APB_CNT_W'(1);
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    // A setup cycle in IDLE or in the completing DONE cycle starts a new transfer
    if (w_accept) begin
      w_addr_nxt  = PADDR;
      w_write_nxt = PWRITE;
      w_wdata_nxt = PWDATA;
      w_viol_nxt  = 1'b0;
      if (WAIT_CYCLES == 0) begin
        w_state_nxt = DONE;
      end else begin
        w_cnt_nxt   = APB_CNT_W'(WAIT_CYCLES - 1);
        w_state_nxt = WAIT;
      end
    end
  end

  assign w_err = w_viol_nxt || !w_n_ok || (w_n_ro && w_write_nxt);
  assign w_we  = (r_state == DONE) && PRESETn && r_write && !r_viol && w_r_ok && !w_r_ro;

  // Forward the committing write so a back-to-back read of the same register sees it
  assign w_rd_data = (w_we && (r_addr == w_addr_nxt)) ? r_wdata : w_mem_rdata;

  apb_slv_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_mem (
    .i_clk     (PCLK),
    .i_we      (w_we),
    .i_waddr   (r_addr[IDX_W-1:0]),
    .i_wdata   (r_wdata),
    .i_raddr   (w_addr_nxt[IDX_W-1:0]),
    .o_rdata_c (w_mem_rdata)
  );

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
      r_viol  <= 1'b0;
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
      PRDATA  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_addr  <= w_addr_nxt;
      r_write <= w_write_nxt;
      r_wdata <= w_wdata_nxt;
      r_viol  <= w_viol_nxt;
      PREADY  <= (w_state_nxt == DONE);
      PSLVERR <= (w_state_nxt == DONE) && w_err;
      PRDATA  <= ((w_state_nxt == DONE) && !w_err && !w_write_nxt) ? w_rd_data : '0;
    end
  end

endmodule

// File: tb/tb_apb_wait_slave.sv
// Directed scoreboard bench for apb_wait_slave: one instance with 2 wait states, one with none.
module tb_apb_wait_slave;
  import apb_pkg::*;

  typedef struct {
    logic [7:0] rdata;
    logic       err;
    int         lat;
  } exp_t;

  logic       clk;
  logic       presetn;
  logic       psel0, psel2, penable, pwrite;
  logic [7:0] paddr, pwdata;
  logic [7:0] prdata0, prdata2;
  logic       pready0, pready2, pslverr0, pslverr2;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic [7:0] got;

  apb_wait_slave #(.WAIT_CYCLES(2)) u_dut2 (
    .PCLK(clk), .PRESETn(presetn), .PSEL(psel2), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata2), .PREADY(pready2), .PSLVERR(pslverr2)
  );

  apb_wait_slave #(.WAIT_CYCLES(0)) u_dut0 (
    .PCLK(clk), .PRESETn(presetn), .PSEL(psel0), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Entered at a negedge; leaves the bus in the access phase during the PREADY cycle.
  task automatic xfer(input bit t2, input bit wr, input logic [7:0] a, input logic [7:0] d,
                      input logic [7:0] erd, input bit eerr, input int elat, input bit chk_rd,
                      output logic [7:0] rd);
    exp_t e;
    int   cyc;
    bit   rdy;
    sb.push_back('{rdata: erd, err: eerr, lat: elat});
    psel0 = !t2; psel2 = t2;
    penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    cyc = 1; rdy = 1'b0;
    while (!rdy && cyc < 40) begin
      @(negedge clk);
      penable = 1'b1;
      pwdata  = ~d;
      cyc++;
      rdy = t2 ? pready2 : pready0;
      if (!rdy) check("slverr_while_wait", 32'(t2 ? pslverr2 : pslverr0), 32'd0);
    end
    e = sb.pop_front();
    check("latency", 32'(cyc), 32'(e.lat));
    rd = t2 ? prdata2 : prdata0;
    check("pslverr", 32'(t2 ? pslverr2 : pslverr0), 32'(e.err));
    if (chk_rd) check("prdata", 32'(rd), 32'(e.rdata));
  endtask

  task automatic idle();
    psel0 = 1'b0; psel2 = 1'b0; penable = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    presetn = 1'b0; psel0 = 1'b0; psel2 = 1'b0; penable = 1'b0;
    pwrite = 1'b0; paddr = '0; pwdata = '0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    check("rst_pready", 32'(pready2), 32'd0);
    check("rst_pslverr", 32'(pslverr2), 32'd0);
    check("rst_prdata", 32'(prdata2), 32'd0);
    check("rst_pready0", 32'(pready0), 32'd0);
    presetn = 1'b1;
    @(negedge clk);

    // Two wait states: write then read back-to-back
    xfer(1, 1, 8'h10, 8'hA5, 8'h00, 0, 4, 0, got);
    xfer(1, 0, 8'h10, 8'h00, 8'hA5, 0, 4, 1, got);
    idle();

    // Zero wait states, back-to-back, including read right after write of same register
    xfer(0, 1, 8'h01, 8'h11, 8'h00, 0, 2, 0, got);
    xfer(0, 1, 8'h02, 8'h22, 8'h00, 0, 2, 0, got);
    xfer(0, 0, 8'h01, 8'h00, 8'h11, 0, 2, 1, got);
    xfer(0, 0, 8'h02, 8'h00, 8'h22, 0, 2, 1, got);
    xfer(0, 1, 8'h03, 8'h44, 8'h00, 0, 2, 0, got);
    xfer(0, 0, 8'h03, 8'h00, 8'h44, 0, 2, 1, got);
    idle();

    // Out of range: 0x40 must not alias register 0x00
    xfer(1, 1, 8'h00, 8'h77, 8'h00, 0, 4, 0, got);
    xfer(1, 1, 8'h40, 8'h5A, 8'h00, 1, 4, 0, got);
    xfer(1, 0, 8'h00, 8'h00, 8'h77, 0, 4, 1, got);
    xfer(1, 0, 8'h40, 8'h00, 8'h00, 1, 4, 1, got);
    idle();

    // Abort: PSEL dropped in first wait cycle
    xfer(1, 1, 8'h05, 8'h3C, 8'h00, 0, 4, 0, got);
    idle();
    psel2 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h05; pwdata = 8'hFF;
    @(negedge clk);
    psel2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_pready", 32'(pready2), 32'd0);
    end
    xfer(1, 0, 8'h05, 8'h00, 8'h3C, 0, 4, 1, got);
    idle();

    // Access phase with no setup: immediate error completion
    psel2 = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 8'h10;
    @(negedge clk);
    check("viol_pready", 32'(pready2), 32'd1);
    check("viol_pslverr", 32'(pslverr2), 32'd1);
    check("viol_prdata", 32'(prdata2), 32'd0);
    idle();
    check("viol_release", 32'(pready2), 32'd0);

    // Reset during WAIT: no write, clean outputs, next transfer works
    psel2 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h10; pwdata = 8'h99;
    @(negedge clk);
    penable = 1'b1;
    presetn = 1'b0;
    @(negedge clk);
    check("mid_rst_pready", 32'(pready2), 32'd0);
    check("mid_rst_pslverr", 32'(pslverr2), 32'd0);
    check("mid_rst_prdata", 32'(prdata2), 32'd0);
    check("mid_rst_state", 32'(u_dut2.r_state), 32'(IDLE));
    presetn = 1'b1;
    idle();
    xfer(1, 0, 8'h10, 8'h00, 8'hA5, 0, 4, 1, got);
    idle();

`ifdef APB_SLV_RO_REGION_EN
    // Read-only region: write errors, contents kept
    xfer(1, 0, 8'h3C, 8'h00, 8'h00, 0, 4, 0, got);
    idle();
    begin
      logic [7:0] prev;
      prev = got;
      xfer(1, 1, 8'h3C, 8'h33, 8'h00, 1, 4, 0, got);
      xfer(1, 0, 8'h3C, 8'h00, prev, 0, 4, 1, got);
    end
    idle();
`else
    xfer(1, 1, 8'h3C, 8'h33, 8'h00, 0, 4, 0, got);
    xfer(1, 0, 8'h3C, 8'h00, 8'h33, 0, 4, 1, got);
    idle();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/apb_wait_slave.md
Name: apb_wait_slave

Overview:
- Downstream APB completer for the master bridge's PSEL1 port: an 8-bit register file with a programmable number of wait states and an error response.
- Consumes the bridge's PSEL/PENABLE/PWRITE/PADDR[7:0]/PWDATA.
- Returns PRDATA/PREADY/PSLVERR, all registered.
- Replaces the combinational zero-wait slave so the bridge's ENABLE-hold and PSLVERR paths can be exercised.

Parameters:
- ADDR_W, 8: PADDR width.
- DATA_W, 8: PWDATA/PRDATA width.
- DEPTH, 64: number of implemented registers; valid addresses are 0..DEPTH-1.
- WAIT_CYCLES, 2: access-phase cycles with PREADY=0 before completion; legal range 0..15.

Ports:
- PCLK  in  1  clock; all logic on the rising edge.
- PRESETn  in  1  synchronous, active-low reset.
- PSEL  in  1  slave select.
- PENABLE  in  1  access phase.
- PWRITE  in  1  1=write, 0=read.
- PADDR  in  ADDR_W  register address.
- PWDATA  in  DATA_W  write data.
- PRDATA  out  DATA_W  read data; valid only while PREADY=1 on a read.
- PREADY  out  1  transfer completes in this cycle.
- PSLVERR  out  1  error; valid only while PREADY=1.

Behaviour:
- Reset: one clock, synchronous, active-low. PRESETn=0 at a rising edge sets state=IDLE, wait counter=0, PREADY=0, PSLVERR=0, PRDATA=0.
  - Memory contents are not reset.
  - Reset mid-transfer aborts the transfer with no write committed.
- FSM states: IDLE, WAIT, DONE. All outputs are registered.
  - IDLE: PSEL=1 and PENABLE=0 (setup cycle) latches PADDR, PWRITE and PWDATA. If WAIT_CYCLES=0, go to DONE; otherwise load cnt=WAIT_CYCLES-1 and go to WAIT.
  - WAIT: PREADY=0. If cnt=0, go to DONE; otherwise cnt-1. PSEL=0 at any point aborts to IDLE with no write.
  - DONE: PREADY=1 for exactly one cycle, then return to IDLE.
    - A setup cycle seen during this same cycle is accepted as the next transfer, so back-to-back transfers are supported.
- Latency: a transfer takes exactly 2+WAIT_CYCLES cycles, setup through the PREADY cycle inclusive.
- Write commit: memory is written on the rising edge that ends the DONE cycle, only if PWRITE=1 and the address is valid. Latched address and data are used, not the live bus values.
- Read: PRDATA = mem[latched addr] in the DONE cycle; 0 in all other cycles.
- Error: latched addr >= DEPTH gives PSLVERR=1 in the DONE cycle. No write occurs and PRDATA=0.
- Protocol violation: PSEL=1 and PENABLE=1 in IDLE with no preceding setup goes to DONE next cycle with PSLVERR=1 and no memory access.
- PSLVERR=0 whenever PREADY=0.
- Live PADDR/PWDATA changes during WAIT are ignored.

Optional Feature:
- Macro APB_SLV_RO_REGION_EN.
- Defined:
  - Addresses DEPTH-8..DEPTH-1 are read-only.
  - A write to them completes normally in timing, with PSLVERR=1 in the DONE cycle and memory unchanged.
  - Reads of them behave as normal.
- Undefined: all valid addresses are read/write; this logic is absent.

Decomposition:
- Shared package apb_pkg:
  - state enum {IDLE, WAIT, DONE};
  - APB_ADDR_W=8 and APB_DATA_W=8;
  - slave-select address bit index (8).
- Sub-module apb_slv_mem: DEPTH x DATA_W array with synchronous write-enable and asynchronous read. It is instantiated once; the FSM/counter remains in apb_wait_slave.

Test Plan:
- Write then read, WAIT_CYCLES=2: write 0xA5 to 0x10, then read 0x10.
  - Each transfer takes 4 cycles.
  - PREADY rises in cycle 4 only.
  - The read returns PRDATA=0xA5 with PSLVERR=0.
- WAIT_CYCLES=0, back-to-back:
  - Write 0x11 to addr 0x01, then 0x22 to 0x02, then read both.
  - Each transfer takes 2 cycles with no idle cycle between.
  - Reads return 0x11 and 0x22.
- Out-of-range: write 0x5A to 0x40 (DEPTH=64).
  - PREADY=1 and PSLVERR=1 in cycle 4.
  - A following read of 0x00 returns its prior value unchanged.
- Abort: drop PSEL in the first WAIT cycle of a write of 0xFF to 0x05.
  - PREADY stays 0.
  - A subsequent read of 0x05 returns the old value.
- Reset mid-transfer: assert PRESETn=0 in WAIT.
  - The next cycle shows PREADY=0, PSLVERR=0, PRDATA=0 and state IDLE.
  - A new transfer then succeeds.
- APB_SLV_RO_REGION_EN defined: write 0x33 to 0x3C.
  - PSLVERR=1.
  - A read of 0x3C returns its previous contents with PSLVERR=0.
